// File: rtl/uart_xmtr_128.sv
// uart_xmtr_128: serialises a 128-bit word as start bit, 128 data bits LSB first, odd parity, stop bit.
// Optional macro UART_XMTR_PARITY_INJECT_EN adds parity_err to send one frame with even parity.
module uart_xmtr_128 #(
    parameter int BIT_TICKS = 16,
    parameter int DATA_BITS = 128
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data_in,
`ifdef UART_XMTR_PARITY_INJECT_EN
    input  logic                 parity_err,
`endif
    output logic                 UART_TX,
    output logic                 busy,
    output logic                 done
);

    localparam int TICK_W = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic accept;
    logic last_tick;
    logic frame_parity;

    function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
        return ~(^d);
    endfunction

    function automatic logic line_level(input logic [2:0] st, input logic lsb, input logic par);
        logic lvl;
        case (st)
            S_START:  lvl = 1'b0;
            S_DATA:   lvl = lsb;
            S_PARITY: lvl = par;
            default:  lvl = 1'b1;
        endcase
        return lvl;
    endfunction

`ifdef UART_XMTR_PARITY_INJECT_EN
    assign frame_parity = odd_parity(data_in) ^ parity_err;
`else
    assign frame_parity = odd_parity(data_in);
`endif

    // busy drops during the last stop tick, so a start seen there launches the next frame gaplessly
    assign accept    = start && !busy_q;
    assign last_tick = (tick_q == TICK_LAST);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_START;
                    tick_d  = '0;
                    bit_d   = '0;
                    shift_d = data_in;
                    par_d   = frame_parity;
                end
            end
            S_START: begin
                if (last_tick) begin
                    state_d = S_DATA;
                    tick_d  = '0;
                    bit_d   = '0;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            S_DATA: begin
                if (last_tick) begin
                    tick_d  = '0;
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    if (bit_q == BIT_LAST) begin
                        state_d = S_PARITY;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            S_PARITY: begin
                if (last_tick) begin
                    state_d = S_STOP;
                    tick_d  = '0;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            S_STOP: begin
                if (last_tick) begin
                    tick_d = '0;
                    if (accept) begin
                        state_d = S_START;
                        bit_d   = '0;
                        shift_d = data_in;
                        par_d   = frame_parity;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tick_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_comb begin
        tx_d   = line_level(state_d, shift_d[0], par_d);
        done_d = (state_d == S_STOP) && (tick_d == TICK_LAST);
        busy_d = (state_d != S_IDLE) && !done_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clock) begin
        shift_q <= shift_d;
        par_q   <= par_d;
    end

    assign UART_TX = tx_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
